regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle register unit, for the pipelined core.
- Multi-read-port register array with writeback bypass and a per-register busy scoreboard tracking in-flight writes.
- Adds a sequential clear engine for soft reset of architectural state.
- Sits between decode/issue (reads, issue reservation) and writeback (write, scoreboard release).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (power of 2, >=2); AW = $clog2(NREGS)
NRD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NRD  read register i has a pending writer
issue_valid  in  1  decode requests reservation of issue_rd
issue_rd  in  AW  destination register being issued
issue_ready  out  1  reservation accepted this cycle when issue_valid
wb_valid  in  1  writeback this cycle
wb_rd  in  AW  writeback destination
wb_data  in  XLEN  writeback data
clear_req  in  1  start clear sweep (sampled in IDLE only)
clear_busy  out  1  clear sweep in progress
dbg_sel  in  AW  debug/display register select
dbg_data  out  XLEN  array contents of dbg_sel, no bypass

Behaviour:
- Reset (async, rst_n=0): all registers 0, all busy bits 0, FSM IDLE, clear counter 0; outputs: rd_busy=0, issue_ready=1, clear_busy=0, rd_data/dbg_data=0.
- Zero register (ZERO_REG=1): reads of addr 0 return 0, rd_busy=0; writes and issues to 0 accepted but have no effect.
- Write: on posedge, if wb_valid && state==IDLE && writable(wb_rd): reg[wb_rd]<=wb_data, busy[wb_rd]<=0.
- Read (combinational): rd_data_i = bypass ? wb_data : reg[rd_addr_i]; bypass = wb_valid && state==IDLE && writable && wb_rd==rd_addr_i.
- rd_busy_i = busy[rd_addr_i] && !bypass.
- Issue: issue_ready = state==IDLE && !(busy[issue_rd] && !(wb_valid && wb_rd==issue_rd)).
  - Accepted (valid && ready, writable): busy[issue_rd]<=1.
  - Simultaneous wb and issue to same reg: data written, busy stays 1 (new writer wins over release).
  - Issue to busy reg with no wb on it: issue_ready=0, no state change (WAW stall).
- FSM states IDLE, CLEAR:
  - IDLE -> CLEAR when clear_req=1.
  - On entry, all busy bits <=0 and counter <= (ZERO_REG ? 1 : 0).
  - CLEAR: reg[counter]<=0, counter++ each cycle; -> IDLE after writing NREGS-1.
  - Sweep lasts NREGS-ZERO_REG cycles; clear_busy=1 throughout; issue_ready=0.
  - wb_valid ignored during CLEAR (no write, no bypass); clear_req ignored in CLEAR.
  - Reads during CLEAR return array contents, partially cleared.
  - rst_n low mid-sweep: immediate return to reset state.
- Latency: write visible in array next cycle; visible same cycle through bypass.

Optional Feature:
- Macro REGFILE_WB_BYPASS_EN.
- Defined: bypass as described.
- Undefined:
  - rd_data_i = reg[rd_addr_i] always.
  - rd_busy_i = busy[rd_addr_i] (pending until the cycle after writeback).
  - issue_ready ignores a same-cycle wb, so issue to a busy register stalls one extra cycle.
  - Scoreboard, write and clear behaviour unchanged.

Test Plan:
- Reset then read ports 0,1 at regs 5,31 -> rd_data=0, rd_busy=0, issue_ready=1, clear_busy=0.
- Issue rd=7; next cycle read 7 -> rd_busy=1; wb 7 with 0xDEADBEEF -> same cycle rd_data=0xDEADBEEF, rd_busy=0 (bypass on); next cycle array=0xDEADBEEF, busy 0.
- Issue rd=7 while busy, no wb -> issue_ready=0. Same cycle as wb 7=0x1234 -> issue_ready=1; next cycle reg7=0x1234, busy[7]=1.
- ZERO_REG=1: wb 0=0xFFFFFFFF plus issue 0 -> read 0 returns 0, rd_busy=0.
- Fill regs 1..31 with index; clear_req -> clear_busy=1 for 31 cycles, issue_ready=0, wb to 3 ignored; afterwards all regs 0, busy 0. Repeat with rst_n pulsed low at sweep cycle 10 -> immediate IDLE, all 0.
- Compile without REGFILE_WB_BYPASS_EN: wb 9=0x55 while reading 9 -> old value and rd_busy=1 that cycle; 0x55 and rd_busy=0 next cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with per-register busy scoreboard and a sequential clear sweep.
// Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle writeback data to reads and issue.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                clear_req,
  output logic                clear_busy,
  input  logic [AW-1:0]       dbg_sel,
  output logic [XLEN-1:0]     dbg_data
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW-1:0]   clr_cnt;

  logic wb_en;
  logic issue_wb_hit;
  logic issue_en;

  function automatic logic writable(input logic [AW-1:0] a);
    return !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wb_en = wb_valid && (state == IDLE) && writable(wb_rd);

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          byp;
      assign addr = rd_addr[gi*AW +: AW];
`ifdef REGFILE_WB_BYPASS_EN
      assign byp = wb_en && (wb_rd == addr);
`else
      assign byp = 1'b0;
`endif
      assign rd_data[gi*XLEN +: XLEN] = byp ? wb_data : (writable(addr) ? regs[addr] : '0);
      assign rd_busy[gi]              = busy[addr] && !byp;
    end
  endgenerate

`ifdef REGFILE_WB_BYPASS_EN
  assign issue_wb_hit = wb_valid && (wb_rd == issue_rd);
`else
  assign issue_wb_hit = 1'b0;
`endif

  // A busy destination stalls issue (WAW) unless its writer retires this cycle.
  assign issue_ready = (state == IDLE) && !(busy[issue_rd] && !issue_wb_hit);
  assign issue_en    = issue_valid && issue_ready && writable(issue_rd);

  assign clear_busy = (state == CLEAR);
  assign dbg_data   = regs[dbg_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
      busy    <= '0;
      // NOTE: the array is reset explicitly because architectural state must read 0 after reset.
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_en) begin
            regs[wb_rd] <= wb_data;
            busy[wb_rd] <= 1'b0;
          end
          // NOTE: later non-blocking assignments win, so a new issue overrides a same-cycle release
          // and a clear request overrides both.
          if (issue_en) busy[issue_rd] <= 1'b1;
          if (clear_req) begin
            state   <= CLEAR;
            busy    <= '0;
            clr_cnt <= AW'((ZERO_REG != 0) ? 1 : 0);
          end
        end
        CLEAR: begin
          regs[clr_cnt] <= '0;
          clr_cnt       <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(NREGS - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
